// File: rtl/result_serializer.sv
// Result matrix serializer: streams the top-left NxN block of a 3x3
// matrix of 16-bit results as bytes to a UART, followed by an XOR checksum.
module result_serializer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   matrix_size,
    input  logic [143:0] result,
    input  logic         tx_busy,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         busy,
    output logic         done
);

    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [143:0]   mat_q, mat_d;
    logic [1:0]     n_q, n_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [7:0]     csum_q, csum_d;
    logic [7:0]     data_q, data_d;
    logic [AW-1:0]  ack_q, ack_d;

    logic [1:0]     n_eff;
    logic [4:0]     nbytes;
    logic           is_data;
    logic [3:0]     elem_seq;
    logic [3:0]     elem_idx;
    logic [15:0]    elem;
    logic [7:0]     cur_byte;

    // Clamp the requested dimension to the 3x3 storage
    always_comb begin
        n_eff = 2'd3;
        if (matrix_size < 4'd4) begin
            n_eff = matrix_size[1:0];
        end
    end

    // Select the current byte: data bytes row-major, high byte first, then checksum
    always_comb begin
        nbytes = 5'd0;
        elem_idx = 4'd0;
        elem_seq = cnt_q[4:1];
        case (n_q)
            2'd1: begin
                nbytes = 5'd2;
                elem_idx = 4'd0;
            end
            2'd2: begin
                nbytes = 5'd8;
                elem_idx = elem_seq + {1'b0, elem_seq[3:1]};
            end
            2'd3: begin
                nbytes = 5'd18;
                elem_idx = elem_seq;
            end
            default: begin
                nbytes = 5'd0;
                elem_idx = 4'd0;
            end
        endcase
        is_data = (cnt_q < nbytes);
        elem = mat_q[{elem_idx, 4'b0000} +: 16];
        if (!is_data) begin
            cur_byte = csum_q;
        end else if (cnt_q[0]) begin
            cur_byte = elem[7:0];
        end else begin
            cur_byte = elem[15:8];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mat_q   <= '0;
            n_q     <= 2'd0;
            cnt_q   <= 5'd0;
            csum_q  <= 8'h00;
            data_q  <= 8'h00;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        mat_d    = mat_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        data_d   = data_q;
        ack_d    = ack_q;
        tx_data  = data_q;
        tx_start = 1'b0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mat_d   = result;
                    n_d     = n_eff;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = 5'd0;
                csum_d  = 8'h00;
                state_d = SEND;
            end
            SEND: begin
                tx_data = cur_byte;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    data_d   = cur_byte;
                    if (is_data) begin
                        csum_d = csum_q ^ cur_byte;
                    end
                    if (cnt_q != 5'd31) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                    ack_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy || ack_q == AW'(ACK_TIMEOUT - 1)) begin
                    state_d = WAIT_DONE;
                end else begin
                    ack_d = ack_q + AW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = (cnt_q > nbytes) ? DONE : SEND;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_serializer.sv
// Randomized bench for result_serializer with a queue-based frame model
// and a simple UART responder.
module tb_result_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   matrix_size = 4'd0;
    logic [143:0] result = '0;
    logic         tx_busy = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int busy_len = 10;
    int dones = 0;
    int cyc = 0;
    byte unsigned got[$];
    byte unsigned exp_q[$];
    int start_cyc[$];

    result_serializer #(.ACK_TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .matrix_size(matrix_size),
        .result(result),
        .tx_busy(tx_busy),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .done(done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and done pulse counter
    initial forever begin
        @(negedge clk);
        cyc++;
        if (done === 1'b1) dones++;
    end

    // UART responder: records launched bytes, raises busy after the launch edge
    initial forever begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
            chk("start_vs_busy", {31'd0, tx_busy}, 32'd0);
            got.push_back(tx_data);
            start_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            if (busy_len > 0) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Expected frame from the matrix and requested size
    task automatic build_exp(input logic [143:0] m, input int ms);
        int n;
        byte unsigned x;
        logic [15:0] el;
        exp_q.delete();
        n = (ms == 0) ? 0 : ((ms > 3) ? 3 : ms);
        x = 8'h00;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                el = m[(3 * r + c) * 16 +: 16];
                exp_q.push_back(el[15:8]);
                exp_q.push_back(el[7:0]);
                x = x ^ el[15:8] ^ el[7:0];
            end
        end
        exp_q.push_back(x);
    endtask

    function automatic logic [143:0] rand_mat();
        logic [143:0] m;
        for (int i = 0; i < 9; i++) m[i * 16 +: 16] = 16'($urandom);
        return m;
    endfunction

    task automatic pulse_start(input logic [143:0] m, input int ms);
        @(negedge clk);
        result = m;
        matrix_size = 4'(ms);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int len);
        for (int i = 0; i < 4000 && dones == 0; i++) @(negedge clk);
        repeat (len + 20) @(negedge clk);
        chk({tag, "_done"}, dones, 1);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF,
                {24'd0, exp_q[i]});
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input logic [143:0] m, input int ms,
                             input int len, input string tag);
        busy_len = len;
        build_exp(m, ms);
        got.delete();
        start_cyc.delete();
        dones = 0;
        pulse_start(m, ms);
        finish_frame(tag, len);
    endtask

    initial begin
        logic [143:0] m;
        int n0;

        #1;
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        matrix_size = 4'd1;
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b1;

        m = rand_mat();
        m[15:0] = 16'h1234;
        run_frame(m, 1, 10, "n1");
        chk("n1_ck", (got.size() > 2) ? {24'd0, got[2]} : 32'hFFFF, 32'h26);

        m = rand_mat();
        m[0 * 16 +: 16] = 16'h0001;
        m[1 * 16 +: 16] = 16'h0002;
        m[3 * 16 +: 16] = 16'h0003;
        m[4 * 16 +: 16] = 16'h0004;
        run_frame(m, 2, 3, "n2");
        chk("n2_ck", (got.size() > 8) ? {24'd0, got[8]} : 32'hFFFF, 32'h04);

        run_frame(rand_mat(), 0, 2, "n0");
        run_frame(rand_mat(), 7, 2, "n7");

        run_frame(rand_mat(), 3, 0, "tmo");
        chk("tmo_gap", (start_cyc.size() > 1) ?
            32'(start_cyc[1] - start_cyc[0]) : 32'hFFFF, 32'd18);

        m = rand_mat();
        busy_len = 4;
        build_exp(m, 3);
        got.delete();
        dones = 0;
        pulse_start(m, 3);
        repeat (30) @(negedge clk);
        pulse_start(~m, 1);
        finish_frame("restart", 4);

        m = rand_mat();
        busy_len = 3;
        got.delete();
        dones = 0;
        pulse_start(m, 3);
        for (int i = 0; i < 2000 && got.size() < 5; i++) @(negedge clk);
        chk("abort_reach5", got.size(), 5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_tx_start", {31'd0, tx_start}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_tx_data", {24'd0, tx_data}, 32'd0);
        n0 = got.size();
        repeat (20) @(negedge clk);
        chk("abort_no_start", got.size(), n0);
        chk("abort_no_done", dones, 0);
        rst = 1'b1;
        run_frame(rand_mat(), 3, 2, "post_rst");

        for (int k = 0; k < 6; k++) begin
            run_frame(rand_mat(), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 6)), $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, giving the max cycles to wait for tx_busy to rise after tx_start.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port start, input, 1, one-cycle request to serialize the result matrix.
REQ-005 SHALL have port matrix_size, input, 4, matrix dimension N.
REQ-006 SHALL have port result, input, 144, 3x3 matrix of 16-bit elements; element (r,c) at bits [(3r+c)*16 +: 16].
REQ-007 SHALL have port tx_busy, input, 1, busy flag from the UART transmitter.
REQ-008 SHALL have port tx_data, output, 8, byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, one-cycle byte launch strobe to the UART transmitter.
REQ-010 SHALL have port busy, output, 1, high whenever the block is not in IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the frame is complete.

Function
REQ-012 SHALL implement states IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, DONE.
REQ-013 In IDLE, start=1 SHALL capture result and the effective N into internal registers and go to LOAD; start in any other state SHALL be ignored.
REQ-014 Effective N SHALL be matrix_size when it is 1..3, 3 when it is above 3, and 0 when it is 0.
REQ-015 LOAD SHALL clear the byte counter and the checksum to 0x00, then go to SEND.
REQ-016 The frame SHALL consist of 2*N*N data bytes followed by one checksum byte.
REQ-017 Data bytes SHALL be in row-major order over the top-left NxN submatrix, high byte of each element first.
REQ-018 The checksum byte SHALL be the XOR of all data bytes in the frame; for N=0 the frame is the single byte 0x00.
REQ-019 SEND SHALL drive tx_data with the current byte, pulse tx_start for exactly one cycle, XOR data bytes into the checksum, and go to WAIT_ACK.
REQ-020 tx_data SHALL stay stable from the SEND cycle until the block leaves WAIT_DONE.
REQ-021 WAIT_ACK SHALL go to WAIT_DONE on tx_busy=1, or after ACK_TIMEOUT cycles with tx_busy still 0.
REQ-022 WAIT_DONE SHALL wait for tx_busy=0, then go to SEND if bytes remain, otherwise to DONE.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE; captured registers SHALL hold their values until the next accepted start.
REQ-024 The byte counter SHALL be 5 bits wide (max 19 bytes) and SHALL NOT wrap within a frame.
REQ-025 tx_start SHALL never be asserted while tx_busy=1 in the same cycle.

Reset
REQ-026 While rst=0, all outputs SHALL clear immediately: tx_data=0x00, tx_start=0, busy=0, done=0, state=IDLE, counters and checksum 0.
REQ-027 Asserting reset mid-frame SHALL abort the frame with no further tx_start.
REQ-028 After reset is released, the block SHALL accept start on the first clock edge.

Verification
REQ-029 Test: N=1, result[15:0]=0x1234, tx_busy high 10 cycles per byte -> bytes 0x12, 0x34, 0x26; 3 tx_start pulses; one done pulse.
REQ-030 Test: N=2, elements (0,0)=0x0001, (0,1)=0x0002, (1,0)=0x0003, (1,1)=0x0004 -> 00 01 00 02 00 03 00 04 04.
REQ-031 Test: matrix_size=0 -> single byte 0x00 then done; matrix_size=7 -> 19 bytes, identical to N=3.
REQ-032 Test: tx_busy held at 0 -> each byte advances after 16 WAIT_ACK cycles; frame still completes with correct bytes.
REQ-033 Test: start pulsed during an active frame -> ignored; frame contents unchanged; exactly one done pulse.
REQ-034 Test: rst=0 after the 5th byte of an N=3 frame -> tx_start, busy and done go low asynchronously; a new start after release sends a full correct frame.
